// File: rtl/i2c_slave_regif_pkg.sv
// i2c_slave_regif_pkg: FSM states and bus-level constants shared by the I2C target
package i2c_slave_regif_pkg;
  typedef enum logic [3:0] {
    IDLE, ADDR, A_ACK, PTR, P_ACK, WR_DATA, W_ACK, RD_DATA, M_ACK, WAIT_STOP
  } state_e;
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  function automatic logic drive_bit(input logic b);
    return ~b;
  endfunction
endpackage

// File: rtl/i2c_slave_regif_if.sv
// i2c_slave_regif_if: open-drain bus pins plus register-file strobes of the I2C target
interface i2c_slave_regif_if #(
  parameter int REG_AW = 8
);
  logic              scl_i;
  logic              sda_i;
  logic              sda_oe;
  logic [REG_AW-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_wr;
  logic              reg_rd;
  logic [7:0]        reg_rdata;
  logic              busy;
  modport slave (
    input  scl_i, sda_i, reg_rdata,
    output sda_oe, reg_addr, reg_wdata, reg_wr, reg_rd, busy
  );
  modport master (
    output scl_i, sda_i, reg_rdata,
    input  sda_oe, reg_addr, reg_wdata, reg_wr, reg_rd, busy
  );
endinterface

// File: rtl/i2c_slave_regif_sync_edge.sv
// i2c_slave_regif_sync_edge: SCL/SDA synchroniser, history flop and START/STOP/edge decode
module i2c_slave_regif_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_s,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);
  logic [SYNC_STAGES-1:0] scl_sr, sda_sr;
  logic                   scl_q, sda_q;
  // Reset to the idle-bus level so no edge is seen on reset release
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      scl_sr <= '1;
      sda_sr <= '1;
      scl_q  <= 1'b1;
      sda_q  <= 1'b1;
    end else begin
      scl_sr <= {scl_sr[SYNC_STAGES-2:0], scl_i};
      sda_sr <= {sda_sr[SYNC_STAGES-2:0], sda_i};
      scl_q  <= scl_s;
      sda_q  <= sda_s;
    end
  assign scl_s     = scl_sr[SYNC_STAGES-1];
  assign sda_s     = sda_sr[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;
endmodule

// File: rtl/i2c_slave_regif.sv
// i2c_slave_regif: I2C target front-end turning bus traffic into register read/write strobes
module i2c_slave_regif
  import i2c_slave_regif_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h29,
  parameter int         REG_AW      = 8,
  parameter int         SYNC_STAGES = 2,
  parameter int         TIMEOUT_CYC = 10000
) (
  input logic              clk,
  input logic              rst_n,
  i2c_slave_regif_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic          scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  state_e        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift, rx;
  logic          rw, tmo_hit;
  logic [TW-1:0] tmo;
  i2c_slave_regif_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst_n(rst_n), .scl_i(bus.scl_i), .sda_i(bus.sda_i),
    .scl_s(scl_s), .sda_s(sda_s), .scl_rise(scl_rise), .scl_fall(scl_fall),
    .start_det(start_det), .stop_det(stop_det)
  );
  assign rx      = {shift[6:0], sda_s};
  assign tmo_hit = state != IDLE && !scl_s && tmo == TW'(TIMEOUT_CYC - 1);
  // ACK phases: first SCL fall starts driving, second fall ends the ACK bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shift         <= '0;
      rw            <= 1'b0;
      tmo           <= '0;
      bus.sda_oe    <= 1'b0;
      bus.reg_addr  <= '0;
      bus.reg_wdata <= '0;
      bus.reg_wr    <= 1'b0;
      bus.reg_rd    <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.reg_wr <= 1'b0;
      bus.reg_rd <= 1'b0;
      tmo        <= (state == IDLE || scl_s || scl_fall) ? '0 : tmo + TW'(1);
      if (bus.reg_rd) shift <= bus.reg_rdata;
      if (start_det) begin
        state      <= ADDR;
        bit_cnt    <= '0;
        bus.sda_oe <= 1'b0;
      end else if (stop_det || tmo_hit) begin
        state      <= IDLE;
        bus.sda_oe <= 1'b0;
        bus.busy   <= 1'b0;
      end else
        case (state)
          ADDR: if (scl_rise) begin
            shift   <= rx;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rw       <= rx[0];
              bus.busy <= rx[7:1] == SLAVE_ADDR;
              state    <= rx[7:1] == SLAVE_ADDR ? A_ACK : IDLE;
            end
          end
          A_ACK: begin
            if (scl_rise && rw) bus.reg_rd <= 1'b1;
            if (scl_fall) begin
              if (!bus.sda_oe) bus.sda_oe <= drive_bit(I2C_ACK);
              else begin
                bit_cnt    <= '0;
                state      <= rw ? RD_DATA : PTR;
                bus.sda_oe <= rw ? drive_bit(shift[7]) : 1'b0;
              end
            end
          end
          PTR: if (scl_rise) begin
            shift   <= rx;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              bus.reg_addr <= REG_AW'(rx);
              state        <= P_ACK;
            end
          end
          P_ACK, W_ACK: if (scl_fall) begin
            if (!bus.sda_oe) bus.sda_oe <= drive_bit(I2C_ACK);
            else begin
              bus.sda_oe <= 1'b0;
              bit_cnt    <= '0;
              state      <= WR_DATA;
              if (state == W_ACK) bus.reg_addr <= bus.reg_addr + REG_AW'(1);
            end
          end
          WR_DATA: if (scl_rise) begin
            shift   <= rx;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              bus.reg_wdata <= rx;
              bus.reg_wr    <= 1'b1;
              state         <= W_ACK;
            end
          end
          RD_DATA: if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              bus.sda_oe <= 1'b0;
              bit_cnt    <= '0;
              state      <= M_ACK;
            end else begin
              shift      <= {shift[6:0], 1'b0};
              bus.sda_oe <= drive_bit(shift[6]);
              bit_cnt    <= bit_cnt + 3'd1;
            end
          end
          M_ACK: begin
            if (scl_rise) begin
              if (sda_s == I2C_NACK) state <= WAIT_STOP;
              else begin
                bus.reg_addr <= bus.reg_addr + REG_AW'(1);
                bus.reg_rd   <= 1'b1;
              end
            end
            if (scl_fall) begin
              state      <= RD_DATA;
              bus.sda_oe <= drive_bit(shift[7]);
            end
          end
          default: ;
        endcase
    end
endmodule
